// File: rtl/cnn_mul_share_arb.sv
// Round-robin share of one signed multiplier among NUM_REQ requesters; NUM_STAGE cycles accept-to-response.
// rsp_valid && !rsp_ready freezes every stage and forces req_ready to zero until the consumer takes the product.
module cnn_mul_share_arb #(
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int DIN0_WIDTH = 9,
   parameter int DIN1_WIDTH = 14,
   parameter int DOUT_WIDTH = 23,
   parameter int NUM_STAGE  = 2
) (
   input  logic                          ap_clk,
   input  logic                          ap_rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0,
   input  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_WIDTH-1:0]           rsp_id,
   output logic [DOUT_WIDTH-1:0]         rsp_dout,
   output logic                          busy
);

   typedef struct packed {
      logic                  vld;
      logic [ID_WIDTH-1:0]   id;
      logic [DOUT_WIDTH-1:0] dat;
   } stage_t;

   stage_t                       stg [NUM_STAGE];
   logic [ID_WIDTH-1:0]          ptr;
   logic [ID_WIDTH-1:0]          grant;
   logic                         found;
   logic                         advance;
   logic                         accept;
   logic [DIN0_WIDTH-1:0]        sel_a;
   logic [DIN1_WIDTH-1:0]        sel_b;
   logic signed [DOUT_WIDTH-1:0] a_ext;
   logic signed [DOUT_WIDTH-1:0] b_ext;
   logic signed [DOUT_WIDTH-1:0] prod;

   assign advance = !rsp_valid || rsp_ready;
   assign accept  = found && advance;

   // Two passes give the wrap-around search: indices >= ptr first, then the lowest one below ptr.
   always_comb begin
      found = 1'b0;
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[i] && (ID_WIDTH'(i) >= ptr)) begin
            found = 1'b1;
            grant = ID_WIDTH'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req_valid[i]) begin
            found = 1'b1;
            grant = ID_WIDTH'(i);
         end
      end
   end

   always_comb begin
      sel_a     = '0;
      sel_b     = '0;
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == ID_WIDTH'(i)) begin
            sel_a        = req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
            sel_b        = req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
            req_ready[i] = accept;
         end
      end
   end

   // Both operands are widened to the product width, so the truncated product is exact.
   assign a_ext = {{(DOUT_WIDTH-DIN0_WIDTH){sel_a[DIN0_WIDTH-1]}}, sel_a};
   assign b_ext = {{(DOUT_WIDTH-DIN1_WIDTH){sel_b[DIN1_WIDTH-1]}}, sel_b};
   assign prod  = a_ext * b_ext;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         ptr <= '0;
         for (int s = 0; s < NUM_STAGE; s++) begin
            stg[s] <= '0;
         end
      end else if (advance) begin
         stg[0].vld <= accept;
         if (accept) begin
            stg[0].id  <= grant;
            stg[0].dat <= prod;
            ptr        <= (grant == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant + 1'b1;
         end
         for (int s = 1; s < NUM_STAGE; s++) begin
            stg[s] <= stg[s-1];
         end
      end
   end

   assign rsp_valid = stg[NUM_STAGE-1].vld;
   assign rsp_id    = stg[NUM_STAGE-1].id;
   assign rsp_dout  = stg[NUM_STAGE-1].dat;

   always_comb begin
      busy = 1'b0;
      for (int s = 0; s < NUM_STAGE; s++) begin
         busy = busy | stg[s].vld;
      end
   end

endmodule

// File: tb/tb_cnn_mul_share_arb.sv
// Directed and random stimulus for cnn_mul_share_arb with a queue scoreboard and a round-robin reference model.
module tb_cnn_mul_share_arb;
   localparam int NUM_REQ    = 4;
   localparam int ID_WIDTH   = 2;
   localparam int DIN0_WIDTH = 9;
   localparam int DIN1_WIDTH = 14;
   localparam int DOUT_WIDTH = 23;
   localparam int NUM_STAGE  = 2;

   logic                          ap_clk = 1'b0;
   logic                          ap_rst_n = 1'b0;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
   logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
   logic                          rsp_valid;
   logic                          rsp_ready;
   logic [ID_WIDTH-1:0]           rsp_id;
   logic [DOUT_WIDTH-1:0]         rsp_dout;
   logic                          busy;

   always #5 ap_clk = ~ap_clk;

   cnn_mul_share_arb #(
      .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .DIN0_WIDTH(DIN0_WIDTH),
      .DIN1_WIDTH(DIN1_WIDTH), .DOUT_WIDTH(DOUT_WIDTH), .NUM_STAGE(NUM_STAGE)
   ) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_din0(req_din0), .req_din1(req_din1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_dout(rsp_dout), .busy(busy)
   );

   typedef struct {
      int id;
      int val;
   } rsp_t;

   rsp_t sb_q[$];
   rsp_t obs_q[$];
   int   gnt_q[$];
   int   a_arr[NUM_REQ];
   int   b_arr[NUM_REQ];
   int   wait_cnt[NUM_REQ];
   int   n_cmp = 0;
   int   n_err = 0;
   int   m_ptr = 0;
   int   m_g;
   logic m_adv;
   logic [NUM_REQ-1:0]    m_exp;
   logic [NUM_REQ-1:0]    acc_mask = '0;
   logic                  prev_stall = 1'b0;
   logic [ID_WIDTH-1:0]   prev_id = '0;
   logic [DOUT_WIDTH-1:0] prev_dout = '0;
   rsp_t                  exp_r;
   int                    exp_rr[14] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 3, 0, 1, 3};
   int                    exp_ext[3] = '{2097152, -2088960, 2088705};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic set_data(input int i, input int a, input int b);
      a_arr[i] = a;
      b_arr[i] = b;
      req_din0[i*DIN0_WIDTH +: DIN0_WIDTH] = DIN0_WIDTH'(a);
      req_din1[i*DIN1_WIDTH +: DIN1_WIDTH] = DIN1_WIDTH'(b);
   endtask

   task automatic send(input int i, input int a, input int b);
      bit got;
      got = 1'b0;
      @(posedge ap_clk); #1;
      set_data(i, a, b);
      req_valid[i] = 1'b1;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge ap_clk);
         got = req_ready[i];
      end
      n_cmp++;
      assert (got) else begin
         n_err++;
         $error("FAIL send_timeout: requester %0d observed no grant expected grant", i);
      end
      @(posedge ap_clk); #1;
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 200) begin
         @(negedge ap_clk);
         t++;
      end
      n_cmp++;
      assert (!busy) else begin
         n_err++;
         $error("FAIL drain_timeout: observed busy=%0b expected 0", busy);
      end
   endtask

   // Reference model and scoreboard, sampled on the falling edge.
   always @(negedge ap_clk) begin
      if (!ap_rst_n) begin
         m_ptr      = 0;
         prev_stall = 1'b0;
         acc_mask   = '0;
         sb_q.delete();
         for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
      end else begin
         m_adv = !rsp_valid || rsp_ready;
         m_g   = -1;
         for (int i = 0; i < NUM_REQ; i++)
            if (m_g < 0 && req_valid[i] && i >= m_ptr) m_g = i;
         for (int i = 0; i < NUM_REQ; i++)
            if (m_g < 0 && req_valid[i]) m_g = i;
         m_exp = '0;
         if (m_g >= 0 && m_adv) m_exp[m_g] = 1'b1;
         check("req_ready", 32'(req_ready), 32'(m_exp));

         if (prev_stall) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_id", 32'(rsp_id), 32'(prev_id));
            check("stall_dout", 32'(rsp_dout), 32'(prev_dout));
         end
         prev_stall = rsp_valid && !rsp_ready;
         prev_id    = rsp_id;
         prev_dout  = rsp_dout;

         if (rsp_valid && rsp_ready) begin
            n_cmp++;
            assert (sb_q.size() > 0) else begin
               n_err++;
               $error("FAIL rsp_unexpected: observed id=%0d dout=%0d expected no response", rsp_id, $signed(rsp_dout));
            end
            if (sb_q.size() > 0) begin
               exp_r = sb_q.pop_front();
               check("rsp_id", 32'(rsp_id), 32'(exp_r.id));
               check("rsp_dout", 32'($signed(rsp_dout)), 32'(exp_r.val));
            end
            obs_q.push_back('{int'(rsp_id), int'($signed(rsp_dout))});
         end

         if (|req_ready) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (req_valid[i] && !req_ready[i]) wait_cnt[i]++;
               else wait_cnt[i] = 0;
               n_cmp++;
               assert (wait_cnt[i] <= NUM_REQ-1) else begin
                  n_err++;
                  $error("FAIL starvation: requester %0d observed %0d grants skipped expected <= %0d", i, wait_cnt[i], NUM_REQ-1);
               end
            end
         end
         for (int i = 0; i < NUM_REQ; i++)
            if (!req_valid[i]) wait_cnt[i] = 0;

         if (m_g >= 0 && m_adv) begin
            sb_q.push_back('{m_g, a_arr[m_g] * b_arr[m_g]});
            gnt_q.push_back(m_g);
            m_ptr = (m_g + 1) % NUM_REQ;
         end
         acc_mask = req_valid & req_ready;
      end
   end

   initial begin
      req_valid = '0;
      rsp_ready = 1'b1;
      req_din0  = '0;
      req_din1  = '0;
      for (int i = 0; i < NUM_REQ; i++) set_data(i, 0, 0);
      #1;
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
      check("rst_dout", 32'(rsp_dout), 32'd0);
      repeat (3) @(posedge ap_clk);
      #2 ap_rst_n = 1'b1;

      // Single request, latency check
      @(posedge ap_clk); #1;
      set_data(0, -3, 100);
      req_valid = 4'b0001;
      @(negedge ap_clk);
      check("single_ready", 32'(req_ready), 32'b0001);
      @(posedge ap_clk); #1;
      req_valid = '0;
      @(negedge ap_clk);
      check("single_lat_early", 32'(rsp_valid), 32'd0);
      check("single_busy", 32'(busy), 32'd1);
      @(negedge ap_clk);
      check("single_lat_valid", 32'(rsp_valid), 32'd1);
      check("single_dout", 32'($signed(rsp_dout)), -32'sd300);
      check("single_id", 32'(rsp_id), 32'd0);
      @(negedge ap_clk);
      check("single_after", 32'(rsp_valid), 32'd0);

      // Arithmetic extremes from requester 2
      wait_idle();
      obs_q.delete();
      send(2, -256, -8192);
      send(2, 255, -8192);
      send(2, 255, 8191);
      wait_idle();
      check("ext_count", 32'(obs_q.size()), 32'd3);
      if (obs_q.size() >= 3) begin
         for (int k = 0; k < 3; k++) begin
            check("ext_dout", 32'(obs_q[k].val), 32'(exp_ext[k]));
            check("ext_id", 32'(obs_q[k].id), 32'd2);
         end
      end

      // Reset with two operations in flight
      @(posedge ap_clk); #1;
      set_data(0, 5, 6);
      set_data(1, 7, 8);
      req_valid = 4'b0011;
      @(posedge ap_clk); #1;
      @(posedge ap_clk); #1;
      req_valid = '0;
      check("mid_busy", 32'(busy), 32'd1);
      ap_rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_dout", 32'(rsp_dout), 32'd0);
      sb_q.delete();
      repeat (2) @(posedge ap_clk);
      #2 ap_rst_n = 1'b1;
      repeat (3) begin
         @(negedge ap_clk);
         check("no_stale_rsp", 32'(rsp_valid), 32'd0);
      end

      // Round-robin order, then requester 2 drops out
      @(posedge ap_clk); #1;
      gnt_q.delete();
      obs_q.delete();
      for (int i = 0; i < NUM_REQ; i++) set_data(i, i + 1, 10 * (i + 1));
      req_valid = '1;
      @(negedge ap_clk);
      check("post_rst_first_grant", 32'(req_ready), 32'b0001);
      repeat (8) @(posedge ap_clk);
      #1 req_valid = 4'b1011;
      repeat (6) @(posedge ap_clk);
      #1 req_valid = '0;
      wait_idle();
      check("rr_count", 32'(gnt_q.size()), 32'd14);
      check("rr_rsp_count", 32'(obs_q.size()), 32'd14);
      if (gnt_q.size() >= 14)
         for (int k = 0; k < 14; k++) check("rr_order", 32'(gnt_q[k]), 32'(exp_rr[k]));

      // Backpressure with a full pipeline
      @(posedge ap_clk); #1;
      req_valid = '1;
      repeat (3) @(posedge ap_clk);
      #1 rsp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge ap_clk);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      end
      @(posedge ap_clk); #1;
      rsp_ready = 1'b1;
      req_valid = '0;
      wait_idle();
      check("bp_left", 32'(sb_q.size()), 32'd0);

      // Random soak
      for (int c = 0; c < 10000; c++) begin
         @(posedge ap_clk); #1;
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] || acc_mask[i]) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               set_data(i, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 16383)) - 8192);
            end
         end
      end
      @(posedge ap_clk); #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      wait_idle();
      check("soak_left", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cnn_mul_share_arb.md
Name: cnn_mul_share_arb

Overview:
- Shares one signed DIN0_WIDTH x DIN1_WIDTH multiplier (9s x 14s -> 23s, DSP48-mapped) among NUM_REQ requesters in the CNN conv/FC datapath.
- Arbitration is round-robin. Each accepted operand pair goes through a NUM_STAGE-deep multiply pipeline.
- Every product comes out on one shared response bus with a requester ID tag and full valid/ready backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_WIDTH, 2, requester tag width, >= clog2(NUM_REQ)
- DIN0_WIDTH, 9, signed operand A width
- DIN1_WIDTH, 14, signed operand B width
- DOUT_WIDTH, 23, signed product width (= DIN0_WIDTH + DIN1_WIDTH)
- NUM_STAGE, 2, multiply pipeline depth in cycles (1..4)

Ports:
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_din0  in  NUM_REQ*DIN0_WIDTH  packed operand A, requester i at bits [i*DIN0_WIDTH +: DIN0_WIDTH]
- req_din1  in  NUM_REQ*DIN1_WIDTH  packed operand B, same packing
- rsp_valid  out  1  product valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  ID_WIDTH  index of requester that issued the product
- rsp_dout  out  DOUT_WIDTH  signed product
- busy  out  1  any pipeline stage holds a valid entry

Behaviour:
- Reset (async assert, sync deassert by the reset tree):
  - all stage valids, rsp_valid and busy = 0
  - rsp_id = 0, rsp_dout = 0
  - RR pointer = 0
  - in-flight operations are dropped with no response; reset mid-operation is legal.
- advance = !rsp_valid || rsp_ready. When advance = 0:
  - the whole pipeline freezes;
  - req_ready = 0;
  - rsp_valid, rsp_id and rsp_dout hold stable.
- Arbitration is combinational and evaluated every cycle:
  - grant = first i with req_valid[i], searching from ptr upward with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ...).
  - req_ready[grant] = advance; all other bits are 0.
  - No req_valid set -> req_ready = 0 and ptr is unchanged.
- Accept = req_valid[i] && req_ready[i]. On accept:
  - the stage-1 register captures din0/din1 of the grant plus ID = grant;
  - ptr <= grant+1, wrapping to 0 at NUM_REQ.
- Requester protocol: a requester must hold valid and data stable until accepted. The block does not depend on this for correctness.
- Arithmetic: full-precision signed product, $signed(din0)*$signed(din1). No truncation or saturation.
  - Extremes: -256*-8192 = +2097152; 255*-8192 = -2088960.
- Pipeline: the valid bit and ID travel with the data. The product may be formed in any stage, provided total latency is NUM_STAGE.
  - Latency: accept at edge k -> rsp_valid=1 after edge k+NUM_STAGE-1, if there are no stalls.
  - Stalls add cycles 1:1.
- Throughput: one accept per cycle while rsp_ready=1. Products emerge in accept order.
- Response: rsp_valid deasserts after the handshake cycle unless the next stage holds a valid entry. There are no bubbles between back-to-back products.
- Simultaneous handshake and accept in the same cycle: allowed. A full pipeline with rsp_ready=1 stays full.
- busy = OR of all stage valids, including the output stage.

Test Plan:
- Single request: NUM_STAGE=2, req_valid=4'b0001, din0=-3, din1=100 -> req_ready[0]=1 for one cycle; rsp_valid=1 two edges after accept; rsp_dout=-300, rsp_id=0.
- Extremes: requester 2 sends (-256,-8192), then (255,-8192), then (255,8191) -> responses +2097152, -2088960, +2088705, in that order, all rsp_id=2.
- Round-robin fairness: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1,... and one product per cycle. Requester 2 dropping valid -> order 0,1,3,0,1,3.
- Backpressure: hold rsp_ready=0 for 5 cycles with the pipeline full -> req_ready=0 throughout; rsp_dout/rsp_id stable. On release, products drain in order with none lost or duplicated.
- Reset mid-operation: pulse ap_rst_n low with 2 operations in flight -> rsp_valid=0, busy=0, ptr=0 immediately (async). No stale response after release; the next request is granted to requester 0 first.
- Random soak: random valids/data on all requesters and random rsp_ready, 10k cycles -> scoreboard matches every product and ID, preserves per-requester order, and shows no starvation beyond NUM_REQ-1 grants.
